// File: rtl/reg_file_pkg.sv
// Shared constants for the prioritised-write register file: conflict counter
// width, its saturation value and the saturating increment helper.
package reg_file_pkg;

  localparam int CONFLICT_CNT_W = 16;
  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = 16'hFFFF;

  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
    return (v == CONFLICT_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/reg_file_prio_sel.sv
// Per-entry write select: finds the lowest-index enabled port addressing ADDR,
// returns its data, and flags when a second enabled port also addresses ADDR.
module reg_file_prio_sel #(
  parameter int WIDTH = 32,
  parameter int NWR   = 2,
  parameter int AW    = 3,
  parameter int ADDR  = 0
) (
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  output logic                 hit,
  output logic [WIDTH-1:0]     sel_data,
  output logic                 collision
);

  localparam logic [AW-1:0] ADDR_V = AW'(ADDR);

  logic [NWR-1:0]   match_s;
  logic             hit_s;
  logic             coll_s;
  logic [WIDTH-1:0] data_s;

  // Per-port address match; disabled ports never match, so their data is never seen.
  always_comb begin
    match_s = {NWR{1'b0}};
    for (int i = 0; i < NWR; i++) begin
      match_s[i] = wr_en[i] && (wr_addr[i*AW +: AW] == ADDR_V);
    end
  end

  // Priority scan from port 0 upward: first match wins, any later match is a collision.
  always_comb begin
    hit_s  = 1'b0;
    coll_s = 1'b0;
    data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NWR; i++) begin
      coll_s = coll_s | (match_s[i] & hit_s);
      data_s = (match_s[i] && !hit_s) ? wr_data[i*WIDTH +: WIDTH] : data_s;
      hit_s  = hit_s | match_s[i];
    end
  end

  assign hit       = hit_s;
  assign sel_data  = data_s;
  assign collision = coll_s;

endmodule

// File: rtl/reg_file_prio_wr.sv
// DEPTH-entry register file with NWR prioritised write ports (port 0 wins),
// NRD combinational read ports and a saturating same-address collision counter.
// Optional REG_FILE_PRIO_BYPASS_EN forwards same-cycle winning write data to reads.
module reg_file_prio_wr
  import reg_file_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 8,
  parameter int               NWR   = 2,
  parameter int               NRD   = 2,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NWR-1:0]            WR_EN,
  input  logic [NWR*AW-1:0]         WR_ADDR,
  input  logic [NWR*WIDTH-1:0]      WR_DATA,
  input  logic [NRD*AW-1:0]         RD_ADDR,
  output logic [NRD*WIDTH-1:0]      RD_DATA,
  output logic                      CONFLICT,
  output logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]          mem_r      [DEPTH];
  logic [WIDTH-1:0]          win_data_s [DEPTH];
  logic [WIDTH-1:0]          view_s     [DEPTH];
  logic [DEPTH-1:0]          hit_s;
  logic [DEPTH-1:0]          coll_s;
  logic                      conflict_r;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_r;
  logic [NRD*WIDTH-1:0]      rd_data_s;

  // Out-of-range write addresses match no entry, so they are dropped and never collide.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    reg_file_prio_sel #(
      .WIDTH (WIDTH),
      .NWR   (NWR),
      .AW    (AW),
      .ADDR  (g)
    ) u_sel (
      .wr_en     (WR_EN),
      .wr_addr   (WR_ADDR),
      .wr_data   (WR_DATA),
      .hit       (hit_s[g]),
      .sel_data  (win_data_s[g]),
      .collision (coll_s[g])
    );
  end

  // Storage array: reset to INIT, otherwise take the winning write or hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_r[a] <= INIT;
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (hit_s[a]) begin
          mem_r[a] <= win_data_s[a];
        end
      end
    end
  end

  // Collision flag pulse and saturating collision-cycle counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_r     <= 1'b0;
      conflict_cnt_r <= {CONFLICT_CNT_W{1'b0}};
    end else begin
      conflict_r <= |coll_s;
      if (|coll_s) begin
        conflict_cnt_r <= sat_inc(conflict_cnt_r);
      end
    end
  end

  // Per-entry read view: stored value, or the same-cycle winning write when bypass is built in.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
`ifdef REG_FILE_PRIO_BYPASS_EN
      view_s[a] = (hit_s[a] && !RST) ? win_data_s[a] : mem_r[a];
`else
      view_s[a] = mem_r[a];
`endif
    end
  end

  // Read ports: out-of-range addresses read as zero.
  always_comb begin
    rd_data_s = {(NRD*WIDTH){1'b0}};
    for (int j = 0; j < NRD; j++) begin
      if ({1'b0, RD_ADDR[j*AW +: AW]} < DEPTH_V) begin
        rd_data_s[j*WIDTH +: WIDTH] = view_s[RD_ADDR[j*AW +: AW]];
      end else begin
        rd_data_s[j*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end
    end
  end

  assign RD_DATA      = rd_data_s;
  assign CONFLICT     = conflict_r;
  assign CONFLICT_CNT = conflict_cnt_r;

endmodule
